// File: rtl/alu_writeback_seq.sv
// ALU result capture and register-file writeback sequencer with the architectural NZCV register (optional ALU_WB_OVERLAP_EN).
// Latency: first write 1 cycle after capture; long multiply writes hi then lo on consecutive cycles.
// Backpressure: wb_ready low holds the current write stable; alu_ready low blocks capture while a writeback is pending.
module alu_writeback_seq #(
    parameter int WIDTH = 32,
    parameter int RADDR = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] Result,
    input  logic [WIDTH-1:0] Result2,
    input  logic [3:0]       ALUFlags,
    input  logic [RADDR-1:0] Rd,
    input  logic [RADDR-1:0] RdLo,
    input  logic             RegWriteReq,
    input  logic [1:0]       FlagWrite,
    input  logic             wb_ready,
    output logic             RegWrite,
    output logic [RADDR-1:0] WA3,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       Flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB1  = 2'd1,
        WB2  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result2_q;
    logic [RADDR-1:0]   rdlo_q;
    logic               long_q;
    logic [3:0]         flags_q;
    logic [RADDR-1:0]   wa3_q, wa3_d;
    logic [WIDTH-1:0]   aluout_q, aluout_d;
    logic               capture;
    logic               is_long;
    logic               final_wr;

    assign is_long  = (ALUControl == 4'b0101) || (ALUControl == 4'b0110);
    assign final_wr = ((state_q == WB1) && !long_q) || (state_q == WB2);

`ifdef ALU_WB_OVERLAP_EN
    assign alu_ready = (state_q == IDLE) || (final_wr && wb_ready);
`else
    assign alu_ready = (state_q == IDLE);
`endif

    assign capture = alu_valid && alu_ready;

    always_comb begin
        state_d  = state_q;
        wa3_d    = wa3_q;
        aluout_d = aluout_q;
        busy     = 1'b0;
        RegWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture && RegWriteReq) begin
                    state_d  = WB1;
                    wa3_d    = Rd;
                    aluout_d = Result;
                end
            end
            WB1: begin
                busy     = 1'b1;
                RegWrite = 1'b1;
                if (wb_ready) begin
                    if (long_q) begin
                        state_d  = WB2;
                        wa3_d    = rdlo_q;
                        aluout_d = result2_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WB2: begin
                busy     = 1'b1;
                RegWrite = 1'b1;
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A capture during the final write starts the next writeback with no bubble.
        if (capture && (state_q != IDLE)) begin
            if (RegWriteReq) begin
                state_d  = WB1;
                wa3_d    = Rd;
                aluout_d = Result;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wa3_q     <= '0;
            aluout_q  <= '0;
        end else begin
            state_q   <= state_d;
            wa3_q     <= wa3_d;
            aluout_q  <= aluout_d;
        end
    end

    // The hi half goes straight into the output register, so only the lo half is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result2_q <= '0;
            rdlo_q    <= '0;
            long_q    <= 1'b0;
            flags_q   <= 4'b0000;
        end else if (capture) begin
            result2_q <= Result2;
            rdlo_q    <= RdLo;
            long_q    <= is_long;
            if (FlagWrite[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagWrite[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign WA3    = wa3_q;
    assign ALUOut = aluout_q;
    assign Flags  = flags_q;

endmodule
